// File: rtl/pipo_pkg.sv
// Shared defaults and word type for the parallel-in/parallel-out register.
package pipo_pkg;

    localparam int unsigned PIPO_WIDTH_DEFAULT = 4;
    localparam int unsigned PIPO_DEPTH_DEFAULT = 1;

    typedef logic [PIPO_WIDTH_DEFAULT-1:0] pipo_word_t;

endpackage : pipo_pkg

// File: rtl/pipo_register_if.sv
// Parallel data bus between a producer (master) and the register (slave).
interface pipo_register_if #(
    parameter int unsigned WIDTH = pipo_pkg::PIPO_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] ins;
    logic [WIDTH-1:0] outs;

    modport master (
        output ins,
        input  outs
    );

    modport slave (
        input  ins,
        output outs
    );

endinterface : pipo_register_if

// File: rtl/pipo_stage.sv
// One WIDTH-bit register stage with synchronous active-high reset to RESET_VAL.
module pipo_stage #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = d_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : pipo_stage

// File: rtl/pipo_register.sv
// Parallel-in/parallel-out register: DEPTH cascaded stages give a fixed DEPTH-cycle delay line.
module pipo_register
    import pipo_pkg::*;
#(
    parameter int unsigned      WIDTH     = PIPO_WIDTH_DEFAULT,
    parameter int unsigned      DEPTH     = PIPO_DEPTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic              clk,
    input logic              rst,
    pipo_register_if.slave   bus
);

    if (WIDTH < 1) begin : g_bad_width
        $error("pipo_register: WIDTH must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("pipo_register: DEPTH must be >= 1");
    end

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] stage_q [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_d[g] = bus.ins;
        end else begin : g_chain
            assign stage_d[g] = stage_q[g-1];
        end

        pipo_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d_i (stage_d[g]),
            .q_o (stage_q[g])
        );
    end

    // Output comes straight from the last flop; no combinational path from ins.
    assign bus.outs = stage_q[DEPTH-1];

endmodule : pipo_register

// File: tb/tb_pipo_register.sv
// Directed, table-driven bench for pipo_register at default params and at DEPTH=3, WIDTH=8.
module tb_pipo_register;
    import pipo_pkg::*;

    typedef struct {
        logic       rst;
        logic [7:0] ins;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipo_register_if #(.WIDTH(4)) bus4 ();
    pipo_register_if #(.WIDTH(8)) bus8 ();

    pipo_register u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    pipo_register #(
        .WIDTH (8),
        .DEPTH (3)
    ) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus8.slave)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: outs=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply4(input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        bus4.ins = v.ins[3:0];
        @(posedge clk);
        #1;
        check(v.name, {4'b0, bus4.outs}, v.exp);
    endtask

    task automatic apply8(input vec_t v);
        @(negedge clk);
        rst3     = v.rst;
        bus8.ins = v.ins;
        @(posedge clk);
        #1;
        check(v.name, bus8.outs, v.exp);
    endtask

    vec_t       v4 [$];
    vec_t       v8 [$];
    pipo_word_t w;

    initial begin
        bus4.ins = 4'b1010;
        bus8.ins = 8'h00;

        v4.push_back('{1'b1, 8'h0A, 8'h00, "reset_edge1"});
        v4.push_back('{1'b1, 8'h0A, 8'h00, "reset_edge2"});
        v4.push_back('{1'b0, 8'h0A, 8'h0A, "reset_release"});
        v4.push_back('{1'b0, 8'h0C, 8'h0C, "basic_1100"});
        v4.push_back('{1'b0, 8'h07, 8'h07, "basic_0111"});
        v4.push_back('{1'b0, 8'h01, 8'h01, "basic_0001"});
        for (int i = 0; i < 16; i++) begin
            w = pipo_word_t'(i);
            v4.push_back('{1'b0, {4'b0, w}, {4'b0, w}, $sformatf("sweep_%0d", i)});
        end
        v4.push_back('{1'b0, 8'h0F, 8'h0F, "hold_1111_a"});
        v4.push_back('{1'b0, 8'h0F, 8'h0F, "hold_1111_b"});
        v4.push_back('{1'b0, 8'h05, 8'h05, "stream_0101"});
        v4.push_back('{1'b1, 8'h06, 8'h00, "midstream_reset"});
        v4.push_back('{1'b0, 8'h09, 8'h09, "post_reset_1001"});

        v8.push_back('{1'b1, 8'hA5, 8'h00, "d3_reset1"});
        v8.push_back('{1'b1, 8'hA5, 8'h00, "d3_reset2"});
        v8.push_back('{1'b0, 8'hA5, 8'h00, "d3_edge1"});
        v8.push_back('{1'b0, 8'h3C, 8'h00, "d3_edge2"});
        v8.push_back('{1'b0, 8'hFF, 8'hA5, "d3_A5"});
        v8.push_back('{1'b0, 8'hFF, 8'h3C, "d3_3C"});
        v8.push_back('{1'b0, 8'h11, 8'hFF, "d3_FF"});
        v8.push_back('{1'b0, 8'h22, 8'hFF, "d3_pre_flush"});
        v8.push_back('{1'b1, 8'h33, 8'h00, "d3_flush"});
        v8.push_back('{1'b0, 8'h44, 8'h00, "d3_refill1"});
        v8.push_back('{1'b0, 8'h55, 8'h00, "d3_refill2"});
        v8.push_back('{1'b0, 8'h66, 8'h44, "d3_refill_44"});
        v8.push_back('{1'b0, 8'h66, 8'h55, "d3_refill_55"});

        foreach (v4[i]) apply4(v4[i]);

        // Glitches between edges must not reach outs.
        @(negedge clk);
        bus4.ins = 4'b0011;
        #2 bus4.ins = 4'b1111;
        #2 bus4.ins = 4'b0011;
        @(posedge clk);
        #1;
        check("glitch_0011", {4'b0, bus4.outs}, 8'h03);
        bus4.ins = 4'b1100;
        #2;
        check("post_edge_change", {4'b0, bus4.outs}, 8'h03);
        @(negedge clk);
        bus4.ins = 4'b0110;
        #3 bus4.ins = 4'b1001;
        @(posedge clk);
        #1;
        check("late_change_1001", {4'b0, bus4.outs}, 8'h09);

        foreach (v8[i]) apply8(v8[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipo_register
